sprite_storage_mp: RTL and testbench
====================================

Name: sprite_storage_mp

Overview:
Parametrised multi-port sprite pixel store, the successor to the fixed 32-sprite, 2-read-port sprite storage. It holds SPRITES bitmaps of SPRITE_PIXELS packed pixels each. Writes arrive on a valid/ready port, one word per beat. A built-in clear engine fills a whole sprite with the transparent colour. READ_PORTS independent registered read ports feed the sprite compositor, and per-sprite loaded flags let unloaded sprites read as transparent.

Parameters:
SPRITES, 32, number of sprite slots; SEL_W = clog2(SPRITES)
SPRITE_PIXELS, 16384, pixels per sprite (power of 2); ADDR_W = clog2(SPRITE_PIXELS)
PIXEL_BITS, 4, bits per pixel (colour index)
W_DATA_BITS, 8, write word width; PPW = W_DATA_BITS/PIXEL_BITS pixels per word (integer, power of 2)
READ_PORTS, 2, number of independent read ports
TRANSPARENT, 0, PIXEL_BITS-wide fill and unloaded-read value

Ports:
clock  in  1  single system clock, rising edge
reset_n  in  1  asynchronous, active-low reset
w_valid  in  1  write request
w_ready  out  1  write accepted when w_valid && w_ready
w_select  in  SEL_W  target sprite
w_addr  in  ADDR_W  pixel address; low clog2(PPW) bits ignored (word aligned)
w_data  in  W_DATA_BITS  PPW pixels; lowest pixel address in bits [PIXEL_BITS-1:0]
clr_valid  in  1  clear request
clr_ready  out  1  clear accepted when clr_valid && clr_ready
clr_select  in  SEL_W  sprite to clear
busy  out  1  clear engine active
sprite_loaded  out  SPRITES  per-sprite loaded flag
r_select  in  READ_PORTS*SEL_W  per-port sprite; port k uses slice k
r_addr  in  READ_PORTS*ADDR_W  per-port pixel address
r_data  out  READ_PORTS*PIXEL_BITS  per-port pixel, registered

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, busy=0, sprite_loaded=0, all r_data=0, clear counter=0.
  - Memory contents are not reset.
- FSM states: IDLE, CLEAR.
- IDLE:
  - clr_ready=1.
  - w_ready = !clr_valid; a clear takes priority over a same-cycle write, which is not accepted.
  - Accepted write stores PPW pixels at word (w_select, w_addr>>log2(PPW)) on the next edge and sets sprite_loaded[w_select].
  - Accepted clear latches clr_select, clears sprite_loaded[clr_select], zeroes the word counter, and moves to CLEAR.
- CLEAR:
  - busy=1, w_ready=0, clr_ready=0.
  - Each cycle writes a word of all-TRANSPARENT pixels at the counter address, then increments the counter.
  - After word SPRITE_PIXELS/PPW-1 the FSM returns to IDLE; busy drops the cycle after the last word is written.
  - Duration is exactly SPRITE_PIXELS/PPW cycles.
- Reads:
  - Always active, including during CLEAR; the ports are fully independent and may address the same location.
  - Latency 1: r_data[k] at edge n+1 reflects r_select/r_addr sampled at edge n.
  - Pixel selected by the low log2(PPW) address bits within the word.
  - If sprite_loaded[sel] was 0 at the sampling edge, the port returns TRANSPARENT regardless of memory contents.
- Read-during-write on the same word (write port or clear engine): read-first, returns the old data. The loaded-flag check also uses the pre-edge flag value.
- Address wrap: the clear counter is an ADDR_W-log2(PPW)-bit counter and must not wrap into a second pass.
- Reset mid-clear: the clear aborts. The sprite's flag stays 0, so it reads TRANSPARENT even though memory is partially filled.
- w_addr / r_addr / r_select out of range (when SPRITES is not a power of 2): writes are dropped, reads return TRANSPARENT.

Test Plan:
1. Reset, then read sprite 3 addr 0 on both ports -> r_data=TRANSPARENT (0) one cycle later, since it is not loaded.
2. Write w_select=5, w_addr=0x0010, w_data=0xA7 -> sprite_loaded[5]=1. A port-0 read of addr 0x0010 returns 0x7 and a port-1 read of 0x0011 returns 0xA, both on the same cycle.
3. Write 0x3C to sprite 5 addr 0x20 while port 0 reads the same pixel in the same cycle -> port 0 returns the old value. A read issued on the next cycle returns 0xC.
4. Issue clr_valid=1 for sprite 5 together with w_valid=1 -> w_ready=0 and the write is not accepted. busy stays high for exactly 8192 cycles, w_ready=0 throughout, and reads of sprite 5 return 0.
5. During a clear of sprite 5, read sprite 6 (previously written 0xF at addr 0) -> returns 0xF with 1-cycle latency, unaffected by the clear.
6. Deassert reset_n 100 cycles into a clear -> busy=0 and state=IDLE immediately. sprite_loaded=0, all r_data=0, and a clear or write is accepted right after reset release.

Source files
------------

// File: rtl/sprite_storage_mp_if.sv
// Sprite store bus: write port, clear request, status flags and READ_PORTS packed read ports.
// Bench/host side drives "master"; the sprite store uses "slave".
interface sprite_storage_mp_if #(
  parameter int SPRITES       = 32,
  parameter int SPRITE_PIXELS = 16384,
  parameter int PIXEL_BITS    = 4,
  parameter int W_DATA_BITS   = 8,
  parameter int READ_PORTS    = 2
);
  localparam int SEL_W  = $clog2(SPRITES);
  localparam int ADDR_W = $clog2(SPRITE_PIXELS);

  logic                             w_valid;
  logic                             w_ready;
  logic [SEL_W-1:0]                 w_select;
  logic [ADDR_W-1:0]                w_addr;
  logic [W_DATA_BITS-1:0]           w_data;
  logic                             clr_valid;
  logic                             clr_ready;
  logic [SEL_W-1:0]                 clr_select;
  logic                             busy;
  logic [SPRITES-1:0]               sprite_loaded;
  logic [READ_PORTS*SEL_W-1:0]      r_select;
  logic [READ_PORTS*ADDR_W-1:0]     r_addr;
  logic [READ_PORTS*PIXEL_BITS-1:0] r_data;

  modport master (
    output w_valid, w_select, w_addr, w_data, clr_valid, clr_select, r_select, r_addr,
    input  w_ready, clr_ready, busy, sprite_loaded, r_data
  );

  modport slave (
    input  w_valid, w_select, w_addr, w_data, clr_valid, clr_select, r_select, r_addr,
    output w_ready, clr_ready, busy, sprite_loaded, r_data
  );
endinterface

// File: rtl/sprite_storage_mp.sv
// Multi-port sprite pixel store with whole-sprite clear engine; reads registered, 1-cycle latency, read-first.
// Backpressure: w_ready low while a clear is requested or running; clr_ready low while clearing.
module sprite_storage_mp #(
  parameter int SPRITES       = 32,
  parameter int SPRITE_PIXELS = 16384,
  parameter int PIXEL_BITS    = 4,
  parameter int W_DATA_BITS   = 8,
  parameter int READ_PORTS    = 2,
  parameter logic [PIXEL_BITS-1:0] TRANSPARENT = '0
) (
  input  logic              clock,
  input  logic              reset_n,
  sprite_storage_mp_if.slave bus
);
  localparam int SEL_W  = $clog2(SPRITES);
  localparam int ADDR_W = $clog2(SPRITE_PIXELS);
  localparam int PPW    = W_DATA_BITS / PIXEL_BITS;
  localparam int OFF_W  = $clog2(PPW);
  localparam int WA_W   = ADDR_W - OFF_W;
  localparam int WORDS  = SPRITE_PIXELS / PPW;
  localparam int IDX_W  = SEL_W + WA_W;
  localparam logic [W_DATA_BITS-1:0] FILL_WORD = {PPW{TRANSPARENT}};

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                 state, state_nxt;
  logic [WA_W-1:0]        clr_cnt, clr_cnt_nxt;
  logic [SEL_W-1:0]       clr_sel, clr_sel_nxt;
  logic [SPRITES-1:0]     loaded, loaded_nxt;
  logic                   mem_we;
  logic [IDX_W-1:0]       mem_idx;
  logic [W_DATA_BITS-1:0] mem_wdat;
  logic                   w_ready, clr_ready, busy;
  logic [W_DATA_BITS-1:0] mem [SPRITES*WORDS];

  // Sub-word pixel bits of w_addr carry no information for a word-wide write.
  wire unused_waddr_lo = ^(bus.w_addr & ADDR_W'(PPW-1));

  function automatic logic sel_ok(input logic [SEL_W-1:0] s);
    return int'(s) < SPRITES;
  endfunction

  always_comb begin
    state_nxt   = state;
    clr_cnt_nxt = clr_cnt;
    clr_sel_nxt = clr_sel;
    loaded_nxt  = loaded;
    mem_we      = 1'b0;
    mem_idx     = {bus.w_select, bus.w_addr[ADDR_W-1:OFF_W]};
    mem_wdat    = bus.w_data;
    w_ready     = 1'b0;
    clr_ready   = 1'b0;
    busy        = 1'b0;
    case (state)
      IDLE: begin
        clr_ready = 1'b1;
        w_ready   = !bus.clr_valid;
        if (bus.clr_valid) begin
          state_nxt   = CLEAR;
          clr_sel_nxt = bus.clr_select;
          clr_cnt_nxt = '0;
          if (sel_ok(bus.clr_select)) loaded_nxt[bus.clr_select] = 1'b0;
        end else if (bus.w_valid && sel_ok(bus.w_select)) begin
          mem_we                     = 1'b1;
          loaded_nxt[bus.w_select]   = 1'b1;
        end
      end
      CLEAR: begin
        busy        = 1'b1;
        mem_we      = sel_ok(clr_sel);
        mem_idx     = {clr_sel, clr_cnt};
        mem_wdat    = FILL_WORD;
        clr_cnt_nxt = clr_cnt + WA_W'(1);
        // Leave on the last word so the counter can never start a second pass.
        if (clr_cnt == WA_W'(WORDS-1)) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      clr_cnt <= '0;
      clr_sel <= '0;
      loaded  <= '0;
    end else begin
      state   <= state_nxt;
      clr_cnt <= clr_cnt_nxt;
      clr_sel <= clr_sel_nxt;
      loaded  <= loaded_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_idx] <= mem_wdat;
  end

  assign bus.w_ready       = w_ready;
  assign bus.clr_ready     = clr_ready;
  assign bus.busy          = busy;
  assign bus.sprite_loaded = loaded;

  for (genvar k = 0; k < READ_PORTS; k++) begin : g_rd
    logic [SEL_W-1:0]       sel;
    logic [ADDR_W-1:0]      addr;
    logic [ADDR_W-1:0]      off;
    logic [W_DATA_BITS-1:0] word;
    logic [W_DATA_BITS-1:0] shifted;
    logic [PIXEL_BITS-1:0]  q;

    assign sel     = bus.r_select[k*SEL_W +: SEL_W];
    assign addr    = bus.r_addr[k*ADDR_W +: ADDR_W];
    assign off     = addr & ADDR_W'(PPW-1);
    assign word    = mem[{sel, addr[ADDR_W-1:OFF_W]}];
    assign shifted = word >> (PIXEL_BITS * int'(off));

    // Memory and flag are both read before this edge's update, giving read-first behaviour.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) q <= '0;
      else          q <= (sel_ok(sel) && loaded[sel]) ? shifted[PIXEL_BITS-1:0] : TRANSPARENT;
    end

    assign bus.r_data[k*PIXEL_BITS +: PIXEL_BITS] = q;
  end
endmodule

// File: tb/tb_sprite_storage_mp.sv
// Directed bench for sprite_storage_mp: pixel-level reference model checked every cycle plus literal spot checks.
module tb_sprite_storage_mp;
  localparam int SPR = 32, SPX = 16384, PB = 4, WB = 8, RP = 2;
  localparam int PPW = WB / PB, WORDS = SPX / PPW, SW = 5, AW = 14;

  logic clock;
  logic reset_n = 1'b0;
  bit   armed   = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;

  sprite_storage_mp_if #(.SPRITES(SPR), .SPRITE_PIXELS(SPX), .PIXEL_BITS(PB),
                         .W_DATA_BITS(WB), .READ_PORTS(RP)) bus ();

  sprite_storage_mp #(.SPRITES(SPR), .SPRITE_PIXELS(SPX), .PIXEL_BITS(PB),
                      .W_DATA_BITS(WB), .READ_PORTS(RP), .TRANSPARENT(4'h0)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #(600000);
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
    end
  endtask

  // Reference model: flat pixel array, loaded flags, and a clear countdown.
  logic [PB-1:0]  m_mem   [SPR*SPX];
  bit             m_known [SPR*SPX];
  logic [SPR-1:0] m_loaded;
  bit             m_busy;
  int             m_clr_sel, m_clr_word;
  logic [PB-1:0]  exp_r     [RP];
  bit             exp_known [RP];

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_loaded   = '0;
      m_busy     = 1'b0;
      m_clr_word = 0;
      for (int k = 0; k < RP; k++) begin
        exp_r[k]     = '0;
        exp_known[k] = 1'b1;
      end
    end else begin
      for (int k = 0; k < RP; k++) begin
        int s, a;
        s = int'(bus.r_select[k*SW +: SW]);
        a = int'(bus.r_addr[k*AW +: AW]);
        if (s >= SPR || !m_loaded[s]) begin
          exp_r[k]     = '0;
          exp_known[k] = 1'b1;
        end else begin
          exp_r[k]     = m_mem[s*SPX + a];
          exp_known[k] = m_known[s*SPX + a];
        end
      end
      if (m_busy) begin
        for (int p = 0; p < PPW; p++) begin
          m_mem[m_clr_sel*SPX + m_clr_word*PPW + p]   = '0;
          m_known[m_clr_sel*SPX + m_clr_word*PPW + p] = 1'b1;
        end
        m_clr_word++;
        if (m_clr_word == WORDS) m_busy = 1'b0;
      end else if (bus.clr_valid) begin
        m_busy     = 1'b1;
        m_clr_sel  = int'(bus.clr_select);
        m_clr_word = 0;
        m_loaded[m_clr_sel] = 1'b0;
      end else if (bus.w_valid) begin
        int s, base;
        s    = int'(bus.w_select);
        base = s*SPX + (int'(bus.w_addr) / PPW) * PPW;
        for (int p = 0; p < PPW; p++) begin
          m_mem[base + p]   = bus.w_data[p*PB +: PB];
          m_known[base + p] = 1'b1;
        end
        m_loaded[s] = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && armed) begin
      check("busy", bus.busy, m_busy);
      check("w_ready", bus.w_ready, !m_busy && !bus.clr_valid);
      check("clr_ready", bus.clr_ready, !m_busy);
      check("sprite_loaded", bus.sprite_loaded, m_loaded);
      for (int k = 0; k < RP; k++)
        if (exp_known[k]) check("r_data_model", bus.r_data[k*PB +: PB], exp_r[k]);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input int s, input int a, input int d);
    bus.w_valid  = 1'b1;
    bus.w_select = SW'(s);
    bus.w_addr   = AW'(a);
    bus.w_data   = WB'(d);
    tick();
    bus.w_valid  = 1'b0;
  endtask

  task automatic set_rd(input int k, input int s, input int a);
    bus.r_select[k*SW +: SW] = SW'(s);
    bus.r_addr[k*AW +: AW]   = AW'(a);
  endtask

  function automatic logic [PB-1:0] rd(input int k);
    return bus.r_data[k*PB +: PB];
  endfunction

  initial begin
    int cnt;
    bus.w_valid = 1'b0; bus.w_select = '0; bus.w_addr = '0; bus.w_data = '0;
    bus.clr_valid = 1'b0; bus.clr_select = '0; bus.r_select = '0; bus.r_addr = '0;
    repeat (3) tick();
    check("reset_busy", bus.busy, 1'b0);
    check("reset_loaded", bus.sprite_loaded, '0);
    check("reset_rdata", bus.r_data, '0);
    reset_n = 1'b1;
    armed   = 1'b1;
    tick();

    // Unloaded sprite reads transparent
    set_rd(0, 3, 0); set_rd(1, 3, 0);
    tick();
    check("unloaded_p0", rd(0), 4'h0);
    check("unloaded_p1", rd(1), 4'h0);

    // Word write, pixel order within the word
    wr(5, 'h10, 'hA7);
    check("loaded5", bus.sprite_loaded[5], 1'b1);
    set_rd(0, 5, 'h10); set_rd(1, 5, 'h11);
    tick();
    check("pix_lo", rd(0), 4'h7);
    check("pix_hi", rd(1), 4'hA);

    // Read-during-write returns old data
    wr(5, 'h20, 'h55);
    wr(6, 'h0, 'h0F);
    set_rd(0, 5, 'h20); set_rd(1, 5, 'h21);
    wr(5, 'h20, 'h3C);
    check("rdw_old_p0", rd(0), 4'h5);
    check("rdw_old_p1", rd(1), 4'h5);
    tick();
    check("rdw_new_p0", rd(0), 4'hC);
    check("rdw_new_p1", rd(1), 4'h3);

    // Clear wins over a same-cycle write; runs exactly WORDS cycles
    bus.clr_valid = 1'b1; bus.clr_select = 5'd5;
    bus.w_valid = 1'b1; bus.w_select = 5'd7; bus.w_addr = '0; bus.w_data = 8'hFF;
    #1;
    check("clr_prio_wready", bus.w_ready, 1'b0);
    check("clr_prio_clrready", bus.clr_ready, 1'b1);
    tick();
    bus.clr_valid = 1'b0; bus.w_valid = 1'b0;
    set_rd(0, 5, 'h10); set_rd(1, 6, 'h0);
    cnt = 0;
    while (bus.busy && cnt < 10000) begin
      if (cnt == 10) begin
        check("clr_rd_s5", rd(0), 4'h0);
        check("clr_rd_s6", rd(1), 4'hF);
        check("clr_wready", bus.w_ready, 1'b0);
      end
      cnt++;
      tick();
    end
    check("clear_cycles", cnt, WORDS);
    check("dropped_write_s7", bus.sprite_loaded[7], 1'b0);
    check("cleared_flag_s5", bus.sprite_loaded[5], 1'b0);
    wr(5, 'h40, 'h99);
    set_rd(0, 5, 'h10); set_rd(1, 5, 'h21);
    tick();
    check("cleared_mem_p0", rd(0), 4'h0);
    check("cleared_mem_p1", rd(1), 4'h0);

    // Reset in the middle of a clear
    bus.clr_valid = 1'b1; bus.clr_select = 5'd6;
    tick();
    bus.clr_valid = 1'b0;
    repeat (100) tick();
    check("midclr_busy", bus.busy, 1'b1);
    reset_n = 1'b0;
    #1;
    check("abort_busy", bus.busy, 1'b0);
    check("abort_clrready", bus.clr_ready, 1'b1);
    check("abort_loaded", bus.sprite_loaded, '0);
    check("abort_rdata", bus.r_data, '0);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    bus.w_valid = 1'b1; bus.w_select = 5'd6; bus.w_addr = AW'(2); bus.w_data = 8'h21;
    #1;
    check("post_rst_wready", bus.w_ready, 1'b1);
    tick();
    bus.w_valid = 1'b0;
    check("post_rst_loaded6", bus.sprite_loaded[6], 1'b1);
    set_rd(0, 6, 'h0); set_rd(1, 6, 'h3);
    tick();
    check("partial_clr_p0", rd(0), 4'h0);
    check("post_rst_wr_p1", rd(1), 4'h2);
    bus.clr_valid = 1'b1; bus.clr_select = 5'd2;
    #1;
    check("post_rst_clrready", bus.clr_ready, 1'b1);
    tick();
    bus.clr_valid = 1'b0;
    check("post_rst_busy", bus.busy, 1'b1);
    cnt = 0;
    while (bus.busy && cnt < 10000) begin
      cnt++;
      tick();
    end
    check("clear2_cycles", cnt, WORDS);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
